// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   PC_W       : program-counter width carried in each queue entry
//   INSTR_W    : instruction word width
//   PC_STEP    : byte increment between sequential instructions
//   fq_entry_t : {pc, instr} pair held by the fetch queue
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Synchronous circular-buffer FIFO of fq_entry_t.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_entry at the tail (ignored when full without pop)
//   i_entry    : entry to write
//   i_pop      : remove the head (ignored when empty)
//   i_flush    : empty the queue; overrides push and pop
//   o_valid    : head entry is valid
//   o_head     : head entry; holds the last shown head while empty
//   o_count    : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  fq_entry_t                i_entry,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic                     o_valid,
  output fq_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t       r_mem [DEPTH];
  fq_entry_t       r_last;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_empty;
  logic            w_full;
  logic            w_do_pop;
  logic            w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~i_flush & ~w_empty;
  // A full queue can still accept a push when the head leaves in the same cycle.
  assign w_do_push = i_push & ~i_flush & (~w_full | w_do_pop);

  // NOTE: storage has no reset; it is only read while the count says the slot
  // is valid, so resetting it would add reset fan-out for no behavioural gain.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      // Remember what decode is seeing so the outputs hold while empty.
      if (!w_empty) begin
        r_last <= r_mem[r_rd_ptr];
      end
      if (i_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        if (w_do_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign o_valid = ~w_empty;
  assign o_head  = w_empty ? r_last : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage in front of a combinational instruction ROM.
// Owns the PC, drives the ROM word address, buffers {pc, instr} pairs and
// hands them to decode over a valid/ready handshake. Redirects flush the queue.
//   clk, rst_n      : clock, asynchronous active-low reset
//   fetch_en        : allow fetching (0 holds the PC, queue still drains)
//   redirect_valid  : load redirect_pc this cycle, flush queue
//   redirect_pc     : redirect target (bits [1:0] ignored)
//   imem_addr       : ROM word address = pc[AW+1:2]
//   imem_q          : ROM data for imem_addr, same cycle
//   out_valid/ready : decode handshake
//   out_instr/pc    : queue head
//   fq_count        : queue occupancy
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int             N        = PC_W,
  parameter int             AW       = 10,
  parameter int             DEPTH    = 2,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [N-1:0]             redirect_pc,
  output logic [AW-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]       imem_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [N-1:0]             out_pc,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int           CW        = $clog2(DEPTH) + 1;
  localparam logic [N-1:0] ALIGN_MSK = ~N'(3);
  localparam logic [N-1:0] PC_RESET  = RESET_PC & ALIGN_MSK;

  logic [N-1:0]   r_pc;
  logic [N-1:0]   w_redirect_pc;
  logic           w_q_valid;
  logic [CW-1:0]  w_q_count;
  fq_entry_t      w_push_entry;
  fq_entry_t      w_head;
  logic           w_deq;
  logic           w_can_enq;
  logic           w_enq;

  assign w_redirect_pc = redirect_pc & ALIGN_MSK;

  assign w_deq     = w_q_valid & out_ready;
  assign w_can_enq = (w_q_count < CW'(DEPTH)) | w_deq;
  assign w_enq     = fetch_en & ~redirect_valid & w_can_enq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= PC_RESET;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_pc;
    end else if (w_enq) begin
      r_pc <= r_pc + N'(PC_STEP);
    end
  end

  // Upper PC bits simply drop off, so the ROM address wraps at 2^AW words.
  assign imem_addr = r_pc[AW+1:2];

  assign w_push_entry.pc    = r_pc;
  assign w_push_entry.instr = imem_q;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_enq),
    .i_entry (w_push_entry),
    .i_pop   (w_deq),
    .i_flush (redirect_valid),
    .o_valid (w_q_valid),
    .o_head  (w_head),
    .o_count (w_q_count)
  );

  assign out_valid = w_q_valid;
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;
  assign fq_count  = w_q_count;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. The ROM is modelled as word k = 0xA000_0000+k.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int N     = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst_n;
  logic          fetch_en;
  logic          redirect_valid;
  logic [N-1:0]  redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_q;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [N-1:0]  out_pc;
  logic [1:0]    fq_count;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(
    .N        (N),
    .AW       (AW),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_q         (imem_q),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fq_count       (fq_count)
  );

  // Combinational ROM model.
  assign imem_q = 32'hA000_0000 + {22'd0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;

    // ---------------- reset state ----------------
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {30'd0, fq_count}, 32'd0);
    check("rst_pc",    out_pc, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_addr",  {22'd0, imem_addr}, 32'd0);
    repeat (3) tick();

    // ---------------- streaming from reset ----------------
    rst_n     = 1'b1;
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    check("rel_valid0", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("str_valid", {31'd0, out_valid}, 32'd1);
      check("str_pc",    out_pc, 32'(4 * k));
      check("str_instr", out_instr, 32'hA000_0000 + 32'(k));
    end
    // Now: head pc 12, count 1, pc register 16.

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_pc_hold", out_pc, 32'd12);
      check("bp_count",   {30'd0, fq_count}, 32'd2);
    end
    check("bp_addr", {22'd0, imem_addr}, 32'd5);   // pc stopped at 20
    out_ready = 1'b1;
    check("bp_head12", out_pc, 32'd12);
    tick();
    check("bp_head16", out_pc, 32'd16);
    check("bp_instr16", out_instr, 32'hA000_0004);
    tick();
    check("bp_head20", out_pc, 32'd20);
    tick();
    check("bp_head24", out_pc, 32'd24);
    check("bp_full",   {30'd0, fq_count}, 32'd2);

    // ---------------- redirect with full queue ----------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    check("rd_valid", {31'd0, out_valid}, 32'd0);
    check("rd_count", {30'd0, fq_count}, 32'd0);
    check("rd_addr",  {22'd0, imem_addr}, 32'h040);
    check("rd_hold",  out_pc, 32'd24);
    tick();
    check("rd_valid1", {31'd0, out_valid}, 32'd1);
    check("rd_pc",     out_pc, 32'h100);
    check("rd_instr",  out_instr, 32'hA000_0040);

    // ---------------- wrap-around ----------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0FFC;
    tick();
    redirect_valid = 1'b0;
    check("wr_addr3ff", {22'd0, imem_addr}, 32'h3FF);
    tick();
    check("wr_pcffc",  out_pc, 32'hFFC);
    check("wr_insffc", out_instr, 32'hA000_03FF);
    check("wr_addr0",  {22'd0, imem_addr}, 32'h000);
    tick();
    check("wr_pc1000",  out_pc, 32'h1000);
    check("wr_ins1000", out_instr, 32'hA000_0000);
    // Now: head 0x1000, count 1, pc register 0x1004.

    // ---------------- fetch disabled ----------------
    fetch_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("fe_valid", {31'd0, out_valid}, 32'd0);
      check("fe_count", {30'd0, fq_count}, 32'd0);
      check("fe_addr",  {22'd0, imem_addr}, 32'h001);
    end
    fetch_en = 1'b1;
    tick();
    check("fe_resume_pc",  out_pc, 32'h1004);
    check("fe_resume_ins", out_instr, 32'hA000_0001);
    tick();
    check("fe_next_pc", out_pc, 32'h1008);

    // ---------------- async reset mid-stream ----------------
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_count", {30'd0, fq_count}, 32'd0);
    check("ar_addr",  {22'd0, imem_addr}, 32'd0);
    check("ar_pc",    out_pc, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("ar_restart_pc",  out_pc, 32'd0);
    check("ar_restart_ins", out_instr, 32'hA000_0000);
    check("ar_restart_v",   {31'd0, out_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_unit
